// File: rtl/shift_sequencer.sv
// Round-robin sequencer sharing one W-bit bidirectional serial shifter between two requesters.
// Optional build macro SEQ_PAUSE_EN adds a Hold input that pauses an active burst.
module shift_sequencer #(
   parameter int W  = 8,
   parameter int CW = 4
) (
   input  logic          Clk,
   input  logic          Reset,
   input  logic [1:0]    Req,
   input  logic          Dir0,
   input  logic          Dir1,
   input  logic [CW-1:0] Cnt0,
   input  logic [CW-1:0] Cnt1,
   input  logic [W-1:0]  Data0,
   input  logic [W-1:0]  Data1,
`ifdef SEQ_PAUSE_EN
   input  logic          Hold,
`endif
   output logic [1:0]    Grant,
   output logic          Busy,
   output logic          Done,
   output logic          Sh_En,
   output logic          Sh_RL,
   output logic          Sh_In
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t        state_r;
   logic          last_r;
   logic          dir_r;
   logic [W-1:0]  data_r;
   logic [CW-1:0] rem_r;
   logic [CW-1:0] idx_r;
   logic [1:0]    grant_r;
   logic          busy_r;
   logic          done_r;

   logic          win_s;
   logic          win_dir_s;
   logic [CW-1:0] win_cnt_s;
   logic [W-1:0]  win_data_s;
   logic [CW-1:0] cnt_sat_s;
   logic          hold_s;
   logic          shifting_s;
   logic [W-1:0]  sh_data_s;

`ifdef SEQ_PAUSE_EN
   assign hold_s = Hold;
`else
   assign hold_s = 1'b0;
`endif

   // Round-robin winner selection and saturation of the winner's count.
   always_comb begin
      win_s = 1'b0;
      if (Req == 2'b11) begin
         win_s = ~last_r;
      end else begin
         win_s = Req[1];
      end
      if (win_s) begin
         win_dir_s  = Dir1;
         win_cnt_s  = Cnt1;
         win_data_s = Data1;
      end else begin
         win_dir_s  = Dir0;
         win_cnt_s  = Cnt0;
         win_data_s = Data0;
      end
      if (win_cnt_s > CW'(W)) begin
         cnt_sat_s = CW'(W);
      end else begin
         cnt_sat_s = win_cnt_s;
      end
   end

   // Sequencer FSM: grant, count out the burst, pulse Done.
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         state_r <= IDLE;
         last_r  <= 1'b1;
         dir_r   <= 1'b0;
         data_r  <= '0;
         rem_r   <= '0;
         idx_r   <= '0;
         grant_r <= 2'b00;
         busy_r  <= 1'b0;
         done_r  <= 1'b0;
      end else begin
         case (state_r)
            IDLE: begin
               if (Req != 2'b00) begin
                  grant_r <= win_s ? 2'b10 : 2'b01;
                  last_r  <= win_s;
                  dir_r   <= win_dir_s;
                  data_r  <= win_data_s;
                  idx_r   <= '0;
                  rem_r   <= cnt_sat_s;
                  busy_r  <= 1'b1;
                  if (cnt_sat_s == '0) begin
                     state_r <= DONE;
                     done_r  <= 1'b1;
                  end else begin
                     state_r <= SHIFT;
                  end
               end
            end
            SHIFT: begin
               if (!hold_s) begin
                  idx_r <= idx_r + CW'(1);
                  rem_r <= rem_r - CW'(1);
                  if (rem_r == CW'(1)) begin
                     state_r <= DONE;
                     done_r  <= 1'b1;
                  end
               end
            end
            DONE: begin
               state_r <= IDLE;
               grant_r <= 2'b00;
               busy_r  <= 1'b0;
               done_r  <= 1'b0;
            end
            default: begin
               state_r <= IDLE;
               grant_r <= 2'b00;
               busy_r  <= 1'b0;
               done_r  <= 1'b0;
            end
         endcase
      end
   end

   // Shifter pins decode only from registered state; Hold just masks the strobe.
   assign shifting_s = (state_r == SHIFT);
   assign sh_data_s  = data_r >> idx_r;
   assign Sh_En      = shifting_s & ~hold_s;
   assign Sh_RL      = shifting_s & dir_r;
   assign Sh_In      = Sh_En & sh_data_s[0];
   assign Grant      = grant_r;
   assign Busy       = busy_r;
   assign Done       = done_r;

endmodule

// File: tb/tb_shift_sequencer.sv
// Scoreboard bench for shift_sequencer: stimulus pushes hand-computed burst results, a monitor checks each burst at Done.
module tb_shift_sequencer;

   logic       Clk = 1'b0;
   logic       Reset;
   logic [1:0] Req;
   logic       Dir0, Dir1;
   logic [3:0] Cnt0, Cnt1;
   logic [7:0] Data0, Data1;
   logic [1:0] Grant;
   logic       Busy, Done, Sh_En, Sh_RL, Sh_In;
`ifdef SEQ_PAUSE_EN
   logic       Hold = 1'b0;
`endif

   shift_sequencer #(.W(8), .CW(4)) dut (
      .Clk(Clk), .Reset(Reset), .Req(Req),
      .Dir0(Dir0), .Dir1(Dir1), .Cnt0(Cnt0), .Cnt1(Cnt1),
      .Data0(Data0), .Data1(Data1),
`ifdef SEQ_PAUSE_EN
      .Hold(Hold),
`endif
      .Grant(Grant), .Busy(Busy), .Done(Done),
      .Sh_En(Sh_En), .Sh_RL(Sh_RL), .Sh_In(Sh_In)
   );

   always #5 Clk = ~Clk;

   typedef struct {
      logic [1:0] grant;
      int         n;
      logic [7:0] bits;
      logic [7:0] shv;
      logic       rl;
      int         busy;
      int         gap;
   } exp_t;

   exp_t sb[$];
   int   total = 0;
   int   bad   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   function automatic exp_t mk(input logic [1:0] g, input int n, input logic [7:0] bits,
                               input logic [7:0] shv, input logic rl, input int busy, input int gap);
      exp_t e;
      e.grant = g; e.n = n; e.bits = bits; e.shv = shv; e.rl = rl; e.busy = busy; e.gap = gap;
      return e;
   endfunction

   // Monitor: model the external shifter and compare each finished burst against the scoreboard.
   int         busy_cnt, nbits, idle_cnt, gap;
   logic       in_burst = 1'b0;
   logic [7:0] bits, shv;
   logic       rl_bad;
   exp_t       e;
   always @(negedge Clk) begin
      if (Reset) begin
         in_burst = 1'b0;
         idle_cnt = 0;
      end else if (Busy) begin
         if (!in_burst) begin
            in_burst = 1'b1;
            busy_cnt = 0; nbits = 0; bits = 8'h00; shv = 8'h00;
            gap = idle_cnt; rl_bad = 1'b0;
         end
         busy_cnt++;
         if (Sh_En) begin
            if (nbits < 8) bits[nbits] = Sh_In;
            nbits++;
            if (sb.size() > 0 && Sh_RL !== sb[0].rl) rl_bad = 1'b1;
            shv = Sh_RL ? {shv[6:0], Sh_In} : {Sh_In, shv[7:1]};
         end else begin
            check("sh_in_idle_zero", {31'd0, Sh_In}, 32'd0);
         end
         if (Done) begin
            if (sb.size() == 0) begin
               check("unexpected_done", 32'd1, 32'd0);
            end else begin
               e = sb.pop_front();
               check("grant", {30'd0, Grant}, {30'd0, e.grant});
               check("shift_count", nbits, e.n);
               check("bit_order", {24'd0, bits}, {24'd0, e.bits});
               check("shifter_value", {24'd0, shv}, {24'd0, e.shv});
               check("busy_len", busy_cnt, e.busy);
               if (e.n > 0) check("sh_rl", {31'd0, rl_bad}, 32'd0);
               if (e.gap >= 0) check("idle_gap", gap, e.gap);
            end
            in_burst = 1'b0;
            idle_cnt = 0;
         end
      end else begin
         in_burst = 1'b0;
         idle_cnt++;
      end
   end

   task automatic drive(input logic [1:0] r, input logic d0, input logic [3:0] c0, input logic [7:0] x0,
                        input logic d1, input logic [3:0] c1, input logic [7:0] x1);
      @(posedge Clk); #1;
      Req = r; Dir0 = d0; Cnt0 = c0; Data0 = x0; Dir1 = d1; Cnt1 = c1; Data1 = x1;
   endtask

   task automatic wait_done(input string name);
      int k;
      k = 0;
      do begin
         @(negedge Clk);
         k++;
      end while (Done !== 1'b1 && k < 60);
      if (Done !== 1'b1) begin
         total++; bad++;
         $display("FAIL %s timeout actual=Done0 required=Done1", name);
      end
   endtask

   task automatic release_req();
      @(posedge Clk); #1;
      Req = 2'b00;
   endtask

   initial begin
      Reset = 1'b1; Req = 2'b00;
      Dir0 = 1'b0; Dir1 = 1'b0; Cnt0 = 4'd0; Cnt1 = 4'd0; Data0 = 8'h00; Data1 = 8'h00;
      #1;
      check("rst_grant", {30'd0, Grant}, 32'd0);
      check("rst_busy",  {31'd0, Busy},  32'd0);
      check("rst_done",  {31'd0, Done},  32'd0);
      check("rst_sh_en", {31'd0, Sh_En}, 32'd0);
      check("rst_sh_rl", {31'd0, Sh_RL}, 32'd0);
      check("rst_sh_in", {31'd0, Sh_In}, 32'd0);
      repeat (2) @(posedge Clk);
      #1 Reset = 1'b0;

      // 8-bit burst from requester 0, shifting toward bit 0.
      sb.push_back(mk(2'b01, 8, 8'hA5, 8'hA5, 1'b0, 9, -1));
      drive(2'b01, 1'b0, 4'd8, 8'hA5, 1'b0, 4'd0, 8'h00);
      wait_done("t1_done");
      release_req();

      // 3-bit burst from requester 1, shifting toward bit W-1.
      sb.push_back(mk(2'b10, 3, 8'b011, 8'b110, 1'b1, 4, -1));
      drive(2'b10, 1'b0, 4'd0, 8'h00, 1'b1, 4'd3, 8'b011);
      wait_done("t2_done");
      release_req();

      // Both requesting continuously: grants alternate with one idle cycle between.
      sb.push_back(mk(2'b01, 2, 8'b01, 8'h40, 1'b0, 3, -1));
      sb.push_back(mk(2'b10, 2, 8'b10, 8'h01, 1'b1, 3, 1));
      sb.push_back(mk(2'b01, 2, 8'b01, 8'h40, 1'b0, 3, 1));
      sb.push_back(mk(2'b10, 2, 8'b10, 8'h01, 1'b1, 3, 1));
      drive(2'b11, 1'b0, 4'd2, 8'b01, 1'b1, 4'd2, 8'b10);
      for (int i = 0; i < 4; i++) wait_done("rr_done");
      release_req();

      // Zero count: Done right after the grant, no shift cycle.
      sb.push_back(mk(2'b01, 0, 8'h00, 8'h00, 1'b0, 1, -1));
      drive(2'b01, 1'b0, 4'd0, 8'hFF, 1'b0, 4'd0, 8'h00);
      wait_done("cnt0_done");
      release_req();

      // Count 15 saturates to 8 shifts.
      sb.push_back(mk(2'b01, 8, 8'h3C, 8'h3C, 1'b0, 9, -1));
      drive(2'b01, 1'b0, 4'd15, 8'h3C, 1'b0, 4'd0, 8'h00);
      wait_done("cnt15_done");
      release_req();

`ifdef SEQ_PAUSE_EN
      // Hold for 3 cycles mid-burst stretches Busy by 3 without changing bits.
      sb.push_back(mk(2'b01, 8, 8'hC3, 8'hC3, 1'b0, 12, -1));
      drive(2'b01, 1'b0, 4'd8, 8'hC3, 1'b0, 4'd0, 8'h00);
      @(posedge Clk);
      @(posedge Clk); #1 Hold = 1'b1;
      repeat (3) @(posedge Clk);
      #1 Hold = 1'b0;
      wait_done("hold_done");
      release_req();
`endif

      // Reset in shift cycle 4: outputs drop at once; requester 0 wins first afterwards.
      drive(2'b01, 1'b0, 4'd8, 8'hFF, 1'b0, 4'd0, 8'h00);
      @(posedge Clk);
      repeat (3) @(posedge Clk);
      #1 Reset = 1'b1;
      #1;
      check("midrst_sh_en", {31'd0, Sh_En}, 32'd0);
      check("midrst_grant", {30'd0, Grant}, 32'd0);
      check("midrst_busy",  {31'd0, Busy},  32'd0);
      @(posedge Clk); #1;
      Reset = 1'b0;
      sb.push_back(mk(2'b01, 2, 8'b01, 8'h40, 1'b0, 3, -1));
      Req = 2'b11; Dir0 = 1'b0; Cnt0 = 4'd2; Data0 = 8'b01; Dir1 = 1'b1; Cnt1 = 4'd2; Data1 = 8'b10;
      wait_done("post_rst_done");
      release_req();

      repeat (4) @(posedge Clk);
      check("scoreboard_empty", sb.size(), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
